// File: rtl/inv_mod_4057_if.sv
// Operand/result handshake bundle for the GF(4057) inverter.
// dout_err exists only when INV_MOD_ZERO_ERR_EN is defined.
interface inv_mod_4057_if;
    logic        din_valid;
    logic        din_ready;
    logic [11:0] din_a;
    logic        dout_valid;
    logic        dout_ready;
    logic [11:0] dout_r;
`ifdef INV_MOD_ZERO_ERR_EN
    logic        dout_err;
`endif

    modport master (
        output din_valid, din_a, dout_ready,
        input  din_ready, dout_valid, dout_r
`ifdef INV_MOD_ZERO_ERR_EN
        , input dout_err
`endif
    );

    modport slave (
        input  din_valid, din_a, dout_ready,
        output din_ready, dout_valid, dout_r
`ifdef INV_MOD_ZERO_ERR_EN
        , output dout_err
`endif
    );
endinterface

// File: rtl/inv_mod_4057.sv
// Modular inverse over GF(Q) via square-and-multiply of din_a^(Q-2); optional INV_MOD_ZERO_ERR_EN adds dout_err.
// Latency: dout_valid rises on the 25th edge after accept, independent of the operand.
// Backpressure: one op in flight; result held in DONE until dout_ready, din_ready low meanwhile.
module inv_mod_4057 #(
    parameter int Q     = 4057,
    parameter int EXP   = 4055,
    parameter int EXP_W = 12,
    parameter int MU    = 4135
) (
    input  logic clk,
    input  logic rst,
    inv_mod_4057_if.slave io
);
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    localparam int               CNT_W    = $clog2(EXP_W);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(EXP_W - 1);
    localparam logic [EXP_W-1:0] EXP_BITS = EXP_W'(EXP);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [11:0]      acc;
    logic [11:0]      base;
    logic             dout_vld_q;
    logic [11:0]      dout_r_q;

    logic [11:0]      mul_b;
    logic [23:0]      prod;
    logic [11:0]      prod_red;
    logic [11:0]      din_red;

    // Barrett: q_est = floor(x*MU / 2^24) undershoots the true quotient by at most 2.
    function automatic logic [11:0] barrett(input logic [23:0] x);
        logic [36:0] t;
        logic [23:0] q_est;
        logic [23:0] r;
        t     = {13'd0, x} * 37'(MU);
        q_est = 24'(t[36:24]);
        r     = x - q_est * 24'(Q);
        if (r >= 24'(Q)) r = r - 24'(Q);
        if (r >= 24'(Q)) r = r - 24'(Q);
        return r[11:0];
    endfunction

    // One shared multiplier: squaring in SQR, multiply-by-base in MUL.
    always_comb begin
        mul_b    = (state == SQR) ? acc : base;
        prod     = {12'd0, acc} * {12'd0, mul_b};
        prod_red = barrett(prod);
        din_red  = (io.din_a >= 12'(Q)) ? io.din_a - 12'(Q) : io.din_a;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (io.din_valid) state_nxt = SQR;
            SQR:  state_nxt = MUL;
            MUL:  state_nxt = (cnt == '0) ? DONE : SQR;
            DONE: if (dout_vld_q && io.dout_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= CNT_TOP;
            acc        <= 12'd1;
            base       <= 12'd0;
            dout_vld_q <= 1'b0;
            dout_r_q   <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.din_valid) begin
                        base <= din_red;
                        acc  <= 12'd1;
                        cnt  <= CNT_TOP;
                    end
                end
                SQR: acc <= prod_red;
                MUL: begin
                    // Slot is always spent, even for zero exponent bits, to keep timing constant.
                    if (EXP_BITS[cnt]) acc <= prod_red;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    if (!dout_vld_q) begin
                        dout_vld_q <= 1'b1;
                        dout_r_q   <= acc;
                    end else if (io.dout_ready) begin
                        dout_vld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.din_ready  = (state == IDLE);
    assign io.dout_valid = dout_vld_q;
    assign io.dout_r     = dout_r_q;
`ifdef INV_MOD_ZERO_ERR_EN
    // base is captured at accept and stays put until the next accept.
    assign io.dout_err   = dout_vld_q && (base == 12'd0);
`endif
endmodule

// File: tb/tb_inv_mod_4057.sv
// Self-checking bench for inv_mod_4057: vector table, hand sequences, random operands vs a Fermat model.
module tb_inv_mod_4057;
    localparam int Q = 4057;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    inv_mod_4057_if io();

    inv_mod_4057 dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int exp_r;
        int exp_err;
    } vec_t;

    function automatic int ref_inv(input int a);
        longint b, r;
        int e;
        b = longint'(a % Q);
        r = 1;
        e = Q - 2;
        while (e > 0) begin
            if (e % 2 == 1) r = (r * b) % Q;
            b = (b * b) % Q;
            e = e / 2;
        end
        return int'(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_err();
`ifdef INV_MOD_ZERO_ERR_EN
        return int'(io.dout_err);
`else
        return 0;
`endif
    endfunction

    // Issue one operand, measure latency, optionally stall the result (and poke din_valid meanwhile).
    task automatic run_op(input int a, input int stall, input bit poke,
                          output int res, output int lat, output int err);
        int guard;
        int ex;
        ex = ref_inv(a);
        res = -1; lat = -1; err = -1; guard = 0;
        while (!io.din_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!io.din_ready) begin
            check("din_ready_wait", 0, 1);
            return;
        end
        io.dout_ready = (stall == 0);
        io.din_valid  = 1'b1;
        io.din_a      = 12'(a);
        @(posedge clk); #1;
        io.din_valid = 1'b0;
        lat = 0;
        while (!io.dout_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!io.dout_valid) begin
            check("dout_valid_timeout", lat, 25);
            return;
        end
        res = int'(io.dout_r);
        err = get_err();
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                io.din_valid = 1'b1;
                io.din_a     = 12'd9;
            end
            @(posedge clk); #1;
            check("stall_valid", int'(io.dout_valid), 1);
            check("stall_r", int'(io.dout_r), ex);
            check("stall_din_ready", int'(io.din_ready), 0);
        end
        io.din_valid  = 1'b0;
        io.dout_ready = 1'b1;
        @(posedge clk); #1;
        check("retire_valid", int'(io.dout_valid), 0);
        check("retire_din_ready", int'(io.din_ready), 1);
        check("retire_err", get_err(), 0);
    endtask

    initial begin
        vec_t tbl[8];
        int   res, lat, err, seen, a, stall;

        tbl[0] = '{2,    2029, 0};
        tbl[1] = '{13,   3745, 0};
        tbl[2] = '{4056, 4056, 0};
        tbl[3] = '{1,    1,    0};
        tbl[4] = '{4058, 1,    0};
        tbl[5] = '{0,    0,    1};
        tbl[6] = '{4057, 0,    1};
        tbl[7] = '{5,    1623, 0};

        io.din_valid  = 1'b0;
        io.din_a      = 12'd0;
        io.dout_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_din_ready", int'(io.din_ready), 1);
        check("rst_dout_valid", int'(io.dout_valid), 0);
        check("rst_dout_r", int'(io.dout_r), 0);
        check("rst_dout_err", get_err(), 0);
        rst = 1'b0;

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, 0, 1'b0, res, lat, err);
            check($sformatf("tbl_r[%0d]", tbl[i].a), res, tbl[i].exp_r);
            check($sformatf("tbl_lat[%0d]", tbl[i].a), lat, 25);
`ifdef INV_MOD_ZERO_ERR_EN
            check($sformatf("tbl_err[%0d]", tbl[i].a), err, tbl[i].exp_err);
`endif
        end

        // Backpressure: 10 stalled cycles with din_valid poked, then exactly one retirement.
        run_op(5, 10, 1'b1, res, lat, err);
        check("stall5_r", res, ref_inv(5));
        check("stall5_lat", lat, 25);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (io.dout_valid) seen++;
        end
        check("stall5_single_retire", seen, 0);

        // Reset mid-operation discards the in-flight result.
        io.din_valid = 1'b1;
        io.din_a     = 12'd7;
        @(posedge clk); #1;
        io.din_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_din_ready", int'(io.din_ready), 1);
        check("midrst_dout_valid", int'(io.dout_valid), 0);
        check("midrst_dout_r", int'(io.dout_r), 0);
        check("midrst_dout_err", get_err(), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (io.dout_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        run_op(7, 0, 1'b0, res, lat, err);
        check("inv7_r", res, ref_inv(7));
        check("inv7_product", (res * 7) % Q, 1);
        check("inv7_lat", lat, 25);

        // Random operands with random result stalls.
        for (int n = 0; n < 300; n++) begin
            a     = int'($urandom_range(1, Q - 1));
            stall = int'($urandom_range(0, 3));
            run_op(a, stall, 1'b0, res, lat, err);
            check($sformatf("rnd_r[%0d]", a), res, ref_inv(a));
            check($sformatf("rnd_prod[%0d]", a), (a * res) % Q, 1);
            check($sformatf("rnd_lat[%0d]", a), lat, 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
